// File: rtl/sys_mem_pkg.sv
// Shared encodings for the sys_mem memory subsystem: FSM states, address
// regions and the default fill value for unmapped reads.
package sys_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_ROM  = 2'd1,
    RGN_NONE = 2'd2
  } region_t;

  localparam logic [7:0] UNMAPPED_DEF = 8'hFF;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: classifies a CPU address as RAM, ROM or
// unmapped and yields the word offset within the selected region.
module mem_region_decode
  import sys_mem_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          RAM_DEPTH = 2048,
  parameter int unsigned ROM_BASE  = 32'hF000,
  parameter int          ROM_DEPTH = 4096,
  parameter int          OFF_W     = 12
) (
  input  logic [ADDR_W-1:0] i_addr,
  output region_t           o_region,
  output logic [OFF_W-1:0]  o_offset
);

  // Bounds are one bit wider so a ROM ending at the top of the map does not wrap.
  localparam logic [ADDR_W:0] ROM_LO = (ADDR_W+1)'(ROM_BASE);
  localparam logic [ADDR_W:0] ROM_HI = ROM_LO + (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W:0] RAM_HI = (ADDR_W+1)'(RAM_DEPTH);

  logic [ADDR_W:0] w_addr_x;
  assign w_addr_x = {1'b0, i_addr};

  always_comb begin
    o_region = RGN_NONE;
    o_offset = '0;
    if (w_addr_x >= ROM_LO && w_addr_x < ROM_HI) begin
      o_region = RGN_ROM;
      o_offset = OFF_W'(i_addr - ADDR_W'(ROM_BASE));
    end else if (w_addr_x < RAM_HI) begin
      o_region = RGN_RAM;
      o_offset = OFF_W'(i_addr);
    end
  end

endmodule

// File: rtl/sys_mem.sv
// Memory subsystem: byte-stream loadable ROM plus RAM behind a req/ready
// handshake with a fixed number of wait states and an error pulse.
module sys_mem
  import sys_mem_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter int                RAM_DEPTH    = 2048,
  parameter int unsigned       ROM_BASE     = 32'hF000,
  parameter int                ROM_DEPTH    = 4096,
  parameter int                WAIT_STATES  = 0,
  parameter int                LOAD_ENABLE  = 1,
  parameter logic [DATA_W-1:0] UNMAPPED_VAL = UNMAPPED_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              req,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int OFF_W  = (RAM_AW > ROM_AW) ? RAM_AW : ROM_AW;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ROM_AW-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_err;
  logic                r_load_done;

  logic [DATA_W-1:0]   r_ram [RAM_DEPTH];
  logic [DATA_W-1:0]   r_rom [ROM_DEPTH];

  region_t             w_region;
  logic [OFF_W-1:0]    w_off;
  logic                w_access;
  logic                w_ram_we;
  logic                w_rom_we;
  logic                w_ptr_last;

  mem_region_decode #(
    .ADDR_W    (ADDR_W),
    .RAM_DEPTH (RAM_DEPTH),
    .ROM_BASE  (ROM_BASE),
    .ROM_DEPTH (ROM_DEPTH),
    .OFF_W     (OFF_W)
  ) u_decode (
    .i_addr   (r_addr),
    .o_region (w_region),
    .o_offset (w_off)
  );

  assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_ram_we   = !reset && w_access && r_we && (w_region == RGN_RAM);
  assign w_rom_we   = !reset && (r_state == ST_LOAD) && load_valid;
  assign w_ptr_last = (r_ptr == ROM_AW'(ROM_DEPTH - 1));

  // Storage carries no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_rom_we) r_rom[r_ptr] <= load_data;
    if (w_ram_we) r_ram[w_off[RAM_AW-1:0]] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= (LOAD_ENABLE != 0) ? ST_LOAD : ST_IDLE;
      r_cnt       <= 4'd0;
      r_ptr       <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (load_valid) begin
            r_ptr <= r_ptr + ROM_AW'(1);
            if (load_last || w_ptr_last) begin
              r_state     <= ST_IDLE;
              r_load_done <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          r_load_done <= 1'b1;
          if (req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_we    <= we;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
            // Writes leave rdata untouched; only reads update it.
            if (r_we) begin
              r_err <= (w_region != RGN_RAM);
            end else begin
              case (w_region)
                RGN_RAM: r_rdata <= r_ram[w_off[RAM_AW-1:0]];
                RGN_ROM: r_rdata <= r_rom[w_off[ROM_AW-1:0]];
                default: begin
                  r_rdata <= UNMAPPED_VAL;
                  r_err   <= 1'b1;
                end
              endcase
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign ready     = r_ready;
  assign err       = r_err;
  assign load_done = r_load_done;

endmodule

// File: tb/tb_sys_mem.sv
// Directed bench for sys_mem: three instances (3 wait states, 16-word ROM
// with no wait states, loader disabled) driven from one shared stimulus.
module tb_sys_mem;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  exp_a;
    logic        err_a;
    logic [7:0]  exp_b;
    logic        err_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        req;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;

  logic [7:0]  rdata_a, rdata_b, rdata_c;
  logic        ready_a, ready_b, ready_c;
  logic        err_a, err_b, err_c;
  logic        done_a, done_b, done_c;

  int total = 0;
  int bad   = 0;

  vec_t       vecs [15];
  logic [7:0] ld   [24];

  always #5 clk = ~clk;

  sys_mem #(.WAIT_STATES(3)) u_a (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .req(req),
    .rdata(rdata_a), .ready(ready_a), .err(err_a),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_done(done_a)
  );

  sys_mem #(.WAIT_STATES(0), .ROM_DEPTH(16)) u_b (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .req(req),
    .rdata(rdata_b), .ready(ready_b), .err(err_b),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_done(done_b)
  );

  sys_mem #(.LOAD_ENABLE(0)) u_c (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .req(req),
    .rdata(rdata_c), .ready(ready_c), .err(err_c),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_done(done_c)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle req pulse, then wait (bounded) for u_a's ready; u_b's first ready is captured too.
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                        output logic [7:0] rd_a, output logic e_a, output int lat_a,
                        output logic [7:0] rd_b, output logic e_b, output int lat_b);
    addr  = a;
    we    = w;
    wdata = d;
    req   = 1'b1;
    tick();
    req   = 1'b0;
    lat_a = -1; lat_b = -1;
    rd_a  = 8'h00; rd_b = 8'h00; e_a = 1'b0; e_b = 1'b0;
    for (int n = 1; n <= 20 && lat_a < 0; n++) begin
      tick();
      if (ready_b && lat_b < 0) begin
        lat_b = n; rd_b = rdata_b; e_b = err_b;
      end
      if (ready_a) begin
        lat_a = n; rd_a = rdata_a; e_a = err_a;
      end
    end
    tick();
    chk("ready_one_cycle", {31'd0, ready_a}, 32'd0);
    chk("err_one_cycle", {31'd0, err_a}, 32'd0);
  endtask

  initial begin
    logic [7:0] rd_a, rd_b;
    logic       e_a, e_b;
    int         lat_a, lat_b;

    ld = '{8'hA9, 8'h03, 8'h38, 8'hE9, 8'h02, 8'h8D, 8'h00, 8'h02,
           8'hA2, 8'h10, 8'hCA, 8'hD0, 8'hFD, 8'h4C, 8'h00, 8'hF0,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    vecs[0]  = '{16'hF000, 1'b0, 8'h00, 8'hA9, 1'b0, 8'hA9, 1'b0};
    vecs[1]  = '{16'hF017, 1'b0, 8'h00, 8'h88, 1'b0, 8'hFF, 1'b1};
    vecs[2]  = '{16'hF001, 1'b0, 8'h00, 8'h03, 1'b0, 8'h03, 1'b0};
    vecs[3]  = '{16'h0010, 1'b1, 8'h5A, 8'h03, 1'b0, 8'h03, 1'b0};
    vecs[4]  = '{16'h0010, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b0};
    vecs[5]  = '{16'hF000, 1'b1, 8'h00, 8'h5A, 1'b1, 8'h5A, 1'b1};
    vecs[6]  = '{16'hF000, 1'b0, 8'h00, 8'hA9, 1'b0, 8'hA9, 1'b0};
    vecs[7]  = '{16'h8000, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[8]  = '{16'h0020, 1'b1, 8'h11, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[9]  = '{16'h8000, 1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[10] = '{16'h0020, 1'b0, 8'h00, 8'h11, 1'b0, 8'h11, 1'b0};
    vecs[11] = '{16'h0800, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[12] = '{16'hF00F, 1'b0, 8'h00, 8'hF0, 1'b0, 8'hF0, 1'b0};
    vecs[13] = '{16'hF010, 1'b0, 8'h00, 8'h11, 1'b0, 8'hFF, 1'b1};
    vecs[14] = '{16'hEFFF, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1};

    reset = 1'b1; addr = 16'h0000; wdata = 8'h00; we = 1'b0; req = 1'b0;
    load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    tick();
    tick();
    chk("rst_rdata_a", {24'd0, rdata_a}, 32'd0);
    chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
    chk("rst_err_a", {31'd0, err_a}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_done_b", {31'd0, done_b}, 32'd0);
    chk("rst_done_c", {31'd0, done_c}, 32'd0);
    chk("rst_out_c", {22'd0, rdata_c, ready_c, err_c}, 32'd0);
    reset = 1'b0;
    tick();
    chk("noload_done_c", {31'd0, done_c}, 32'd1);
    chk("load_pending_a", {31'd0, done_a}, 32'd0);

    // Requests during LOAD must be ignored.
    addr = 16'h0010; we = 1'b0; req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("req_in_load_a", {31'd0, ready_a}, 32'd0);
      chk("req_in_load_b", {31'd0, ready_b}, 32'd0);
    end
    req = 1'b0;

    // 24-byte stream; u_b must stop on its own after 16 bytes.
    for (int i = 0; i < 24; i++) begin
      load_valid = 1'b1;
      load_data  = ld[i];
      load_last  = (i == 23);
      tick();
      chk($sformatf("done_a_byte%0d", i), {31'd0, done_a}, {31'd0, (i == 23)});
      chk($sformatf("done_b_byte%0d", i), {31'd0, done_b}, {31'd0, (i >= 15)});
    end
    load_last  = 1'b0;
    load_data  = 8'h00;
    tick();
    tick();
    load_valid = 1'b0;
    tick();
    chk("done_a_sticky", {31'd0, done_a}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].addr, vecs[i].we, vecs[i].wdata, rd_a, e_a, lat_a, rd_b, e_b, lat_b);
      chk($sformatf("v%0d_rdata_a", i), {24'd0, rd_a}, {24'd0, vecs[i].exp_a});
      chk($sformatf("v%0d_err_a", i), {31'd0, e_a}, {31'd0, vecs[i].err_a});
      chk($sformatf("v%0d_lat_a", i), lat_a, 32'd4);
      chk($sformatf("v%0d_rdata_b", i), {24'd0, rd_b}, {24'd0, vecs[i].exp_b});
      chk($sformatf("v%0d_err_b", i), {31'd0, e_b}, {31'd0, vecs[i].err_b});
      chk($sformatf("v%0d_lat_b", i), lat_b, 32'd1);
    end

    // Reset while u_a waits on a RAM write: the write and its ready are dropped.
    addr = 16'h0020; we = 1'b1; wdata = 8'h22; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("abort_pre_ready_a", {31'd0, ready_a}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    addr = 16'h0020; we = 1'b0; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_ready_a", {31'd0, ready_a}, 32'd0);
      chk("abort_in_load_a", {31'd0, done_a}, 32'd0);
    end
    req = 1'b0;
    load_valid = 1'b1; load_data = 8'hA9; load_last = 1'b0;
    tick();
    load_data = 8'h03; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("reload_done_a", {31'd0, done_a}, 32'd1);
    chk("reload_done_b", {31'd0, done_b}, 32'd1);
    access(16'h0020, 1'b0, 8'h00, rd_a, e_a, lat_a, rd_b, e_b, lat_b);
    chk("abort_keep_a", {24'd0, rd_a}, 32'h11);
    chk("abort_err_a", {31'd0, e_a}, 32'd0);
    chk("prereset_write_b", {24'd0, rd_b}, 32'h22);

    // Back-to-back with req held: u_b gives ready every second cycle.
    tick();
    addr = 16'hF000; we = 1'b0; req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("b2b_ready_%0d", i), {31'd0, ready_b}, {31'd0, (i % 2 == 0)});
      if (i % 2 == 0) chk($sformatf("b2b_rdata_%0d", i), {24'd0, rdata_b}, 32'hA9);
    end
    req = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_mem.md
# sys_mem

Parametrised memory subsystem between `cpu_core` and on-chip storage. It holds a ROM region that can be loaded over a byte-stream port after reset, plus a RAM region. Every CPU access goes through a req/ready handshake with a configurable number of wait states. Unmapped reads and illegal ROM writes are flagged with a one-cycle error pulse.

## Interface
Parameters:
- `ADDR_W`, 16: CPU address width.
- `DATA_W`, 8: data width.
- `RAM_DEPTH`, 2048: RAM words, mapped at address 0.
- `ROM_BASE`, 16'hF000: first ROM address.
- `ROM_DEPTH`, 4096: ROM words.
- `WAIT_STATES`, 0: extra cycles per access, range 0..15.
- `LOAD_ENABLE`, 1: 1 enters LOAD after reset; 0 goes straight to IDLE.
- `UNMAPPED_VAL`, 8'hFF: data returned for unmapped reads.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `addr` in ADDR_W: CPU address.
- `wdata` in DATA_W: CPU write data.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `req` in 1: access request, level-sensitive.
- `rdata` out DATA_W: read data, valid while `ready`=1.
- `ready` out 1: one-cycle access-complete pulse.
- `err` out 1: one-cycle pulse, coincident with `ready`, on an unmapped access or a ROM write.
- `load_valid` in 1: loader byte strobe.
- `load_data` in DATA_W: loader byte.
- `load_last` in 1: final loader byte; qualified by `load_valid`.
- `load_done` out 1: high once the FSM has left LOAD.

## Operation
- FSM states: LOAD, IDLE, WAIT.
- Reset:
  - Next state is LOAD if LOAD_ENABLE=1, else IDLE.
  - `rdata`=0, `ready`=0, `err`=0, `load_done`=0.
  - Wait counter=0, load pointer=0.
  - RAM and ROM contents are preserved.
- LOAD:
  - Each cycle with `load_valid`=1 writes ROM[ptr] and increments ptr.
  - The FSM moves to IDLE after the byte with `load_last`=1, or after the byte written at ptr=ROM_DEPTH-1, whichever comes first.
  - `req` is ignored in LOAD; `ready` stays 0.
- IDLE:
  - `req`=1 latches addr, wdata and we, loads cnt=WAIT_STATES, and goes to WAIT.
- WAIT, cnt≠0: cnt decrements.
- WAIT, cnt=0:
  - The access is performed.
  - Next cycle: `ready`=1 and state is IDLE.
- Decode, on the latched address:
  - ROM: ROM_BASE ≤ a < ROM_BASE+ROM_DEPTH.
  - RAM: a < RAM_DEPTH.
  - ROM takes priority if the regions overlap.
  - Anything else is unmapped.
- Read: `rdata` = mem[a−base], or UNMAPPED_VAL with `err`=1 when unmapped.
- Write:
  - RAM is written.
  - ROM and unmapped writes are discarded with `err`=1.
  - `rdata` is unchanged on any write.
- `rdata` holds its value between accesses.
- `req` arriving while in WAIT is ignored; it is not queued.
- Reset mid-access or mid-load: the access is aborted with no write and no `ready`; the load pointer returns to 0.

## Timing
- `req` sampled at edge k → `ready` high in the cycle after edge k+1+WAIT_STATES.
- Read latency is WAIT_STATES+2 cycles, counted from `req`.
- Maximum throughput is one access per WAIT_STATES+2 cycles.
- `req` held high gives back-to-back accesses: the request is re-accepted in the cycle `ready` is high.
- `load_done`:
  - LOAD_ENABLE=1: rises the cycle after the final load byte and stays high until reset.
  - LOAD_ENABLE=0: rises one cycle after `reset` deasserts.
- `load_valid` after loading is complete is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `sys_mem_pkg` holds:
  - the FSM state encoding (LOAD/IDLE/WAIT);
  - the region encoding (RGN_RAM/RGN_ROM/RGN_NONE);
  - the default UNMAPPED_VAL.
- One combinational sub-module, `mem_region_decode`: address in → region plus offset.
- Storage is two inferred synchronous arrays.

## Test plan
- LOAD_ENABLE=1:
  - Stimulus: stream 24 bytes (A9 03 38 E9 02 …) with `load_last` on the 24th.
  - Required: `load_done` rises one cycle later.
  - Then read F000 → A9 and F017 → 88, with `err`=0.
- WAIT_STATES=3:
  - Stimulus: read F001 with `req` at edge k.
  - Required: `ready` high exactly after edge k+4, `rdata`=03.
- RAM:
  - Stimulus: write 0x0010=5A, then read 0x0010.
  - Required: 5A.
  - Stimulus: write F000=00, then read F000.
  - Required: the write pulses `err` and the read still returns A9.
- Unmapped:
  - Stimulus: read 0x8000.
  - Required: `rdata`=FF with `err`=1 for one cycle.
  - Stimulus: `req` during LOAD.
  - Required: no `ready`.
- Reset:
  - Stimulus: assert `reset` during WAIT of a RAM write to 0x0020 (old value 11).
  - Required: no `ready`, 0x0020 still 11, state back to LOAD.
  - Stimulus: a load overrunning ROM_DEPTH=16.
  - Required: stops after 16 bytes, `load_done`=1.
- Back-to-back:
  - Stimulus: `req` held high with WAIT_STATES=0.
  - Required: `ready` every 2nd cycle.
